// File: rtl/pulse_burst_ctrl.sv
// Purpose: accepts one burst command (period, duration, count) and emits count timed pulses on o_pulse, then strobes o_done.
// Latency: first pulse cycle is one cycle after accept; o_done lands count*period+1 cycles after accept; ready returns the cycle after.
// Backpressure: o_cmd_ready is high only in IDLE; commands are not queued. Build with PULSE_BURST_ABORT_EN for the i_abort port.
module pulse_burst_ctrl #(
   parameter int CNT_W   = 8,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [CNT_W-1:0]   i_cmd_period,
   input  logic [CNT_W-1:0]   i_cmd_duration,
   input  logic [BURST_W-1:0] i_cmd_count,
   output logic               o_pulse,
   output logic               o_busy,
   output logic               o_done,
`ifdef PULSE_BURST_ABORT_EN
   output logic [BURST_W-1:0] o_pulse_idx,
   input  logic               i_abort
`else
   output logic [BURST_W-1:0] o_pulse_idx
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

   logic [1:0]         state;
   logic [CNT_W-1:0]   period_q;
   logic [CNT_W-1:0]   duration_q;
   logic [BURST_W-1:0] count_q;
   logic [CNT_W-1:0]   phase;
   logic [BURST_W-1:0] idx;
   logic               abort_req;
   logic               phase_wrap;
   logic               last_pulse;

`ifdef PULSE_BURST_ABORT_EN
   assign abort_req = i_abort;
`else
   assign abort_req = 1'b0;
`endif

   // period_q is never 0 after accept, so period_q-1 cannot underflow
   assign phase_wrap = (phase == (period_q - CNT_ONE));
   assign last_pulse = (idx == (count_q - BURST_ONE));

   // Outputs depend only on registered state: no input-to-output path
   assign o_cmd_ready = (state == S_IDLE);
   assign o_busy      = (state != S_IDLE);
   assign o_done      = (state == S_DONE);
   assign o_pulse     = (state == S_RUN) && (phase < duration_q);
   assign o_pulse_idx = idx;

   // Burst sequencer: command capture, phase/index counting and state transitions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         period_q   <= '0;
         duration_q <= '0;
         count_q    <= '0;
         phase      <= '0;
         idx        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               phase <= '0;
               if (i_cmd_valid) begin
                  // A zero period would never wrap; run it as a one-cycle period
                  period_q   <= (i_cmd_period == '0) ? CNT_ONE : i_cmd_period;
                  duration_q <= i_cmd_duration;
                  count_q    <= i_cmd_count;
                  idx        <= '0;
                  state      <= (i_cmd_count == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (abort_req) begin
                  phase <= '0;
                  state <= S_DONE;
               end else if (phase_wrap) begin
                  phase <= '0;
                  // idx stays at count-1 on the final wrap so it never exceeds the burst
                  if (last_pulse) begin
                     state <= S_DONE;
                  end else begin
                     idx <= idx + BURST_ONE;
                  end
               end else begin
                  phase <= phase + CNT_ONE;
               end
            end
            S_DONE: begin
               phase <= '0;
               state <= S_IDLE;
            end
            default: begin
               phase <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Purpose: self-checking bench for pulse_burst_ctrl using a cycle-indexed burst model.
// Latency: each burst is observed cycle by cycle from the accept edge through the ready cycle.
// Backpressure: exercises held i_cmd_valid while busy and acceptance in the first ready cycle.
module tb_pulse_burst_ctrl;

   localparam int CNT_W   = 8;
   localparam int BURST_W = 8;

   logic               clk;
   logic               rst_n;
   logic               i_cmd_valid;
   logic               o_cmd_ready;
   logic [CNT_W-1:0]   i_cmd_period;
   logic [CNT_W-1:0]   i_cmd_duration;
   logic [BURST_W-1:0] i_cmd_count;
   logic               o_pulse;
   logic               o_busy;
   logic               o_done;
   logic [BURST_W-1:0] o_pulse_idx;
   logic               i_abort;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int p;
      int d;
      int c;
      int done_at;
      int highs;
   } vec_t;

   vec_t tbl[8];

   pulse_burst_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_cmd_valid    (i_cmd_valid),
      .o_cmd_ready    (o_cmd_ready),
      .i_cmd_period   (i_cmd_period),
      .i_cmd_duration (i_cmd_duration),
      .i_cmd_count    (i_cmd_count),
      .o_pulse        (o_pulse),
      .o_busy         (o_busy),
      .o_done         (o_done),
`ifdef PULSE_BURST_ABORT_EN
      .o_pulse_idx    (o_pulse_idx),
      .i_abort        (i_abort)
`else
      .o_pulse_idx    (o_pulse_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return {20'd0, o_pulse, o_done, o_busy, o_cmd_ready, o_pulse_idx};
   endfunction

   function automatic logic [31:0] mk(input logic p, input logic dn, input logic b,
                                      input logic r, input int idx);
      logic [BURST_W-1:0] iv;
      iv = BURST_W'(idx);
      return {20'd0, p, dn, b, r, iv};
   endfunction

   // Drive a command at the current (negedge) time; it is taken at the next rising edge.
   task automatic issue(input int p, input int d, input int c, input bit hold);
      i_cmd_valid    = 1'b1;
      i_cmd_period   = CNT_W'(p);
      i_cmd_duration = CNT_W'(d);
      i_cmd_count    = BURST_W'(c);
      @(posedge clk);
      #1;
      if (!hold) i_cmd_valid = 1'b0;
   endtask

   // Model: cycle k after accept (k>=1). For k<=count*period the pulse is high when
   // (k-1) mod period < duration and the index is (k-1)/period; then one done cycle, then ready.
   task automatic observe(input int p, input int d, input int c,
                          output int done_at, output int highs);
      int pe;
      int len;
      int last_idx;
      logic pb;
      pe       = (p == 0) ? 1 : p;
      len      = c * pe;
      last_idx = (c == 0) ? 0 : c - 1;
      done_at  = -1;
      highs    = 0;
      for (int k = 1; k <= len + 1; k++) begin
         @(negedge clk);
         if (k <= len) begin
            pb = (((k - 1) % pe) < d);
            chk("burst_cycle", obs(), mk(pb, 1'b0, 1'b1, 1'b0, (k - 1) / pe));
         end else begin
            chk("done_cycle", obs(), mk(1'b0, 1'b1, 1'b1, 1'b0, last_idx));
         end
         if (o_pulse) highs++;
         if (o_done) begin
            done_at = k;
            break;
         end
      end
      if (done_at < 0) begin
         for (int w = 0; w < 600 && !o_cmd_ready; w++) @(negedge clk);
      end else begin
         @(negedge clk);
         chk("ready_cycle", obs(), mk(1'b0, 1'b0, 1'b0, 1'b1, last_idx));
      end
   endtask

   initial begin
      int done_at;
      int highs;
      int p;
      int d;
      int c;

      tbl[0] = '{p: 4,   d: 2, c: 3, done_at: 13,  highs: 6};
      tbl[1] = '{p: 0,   d: 1, c: 2, done_at: 3,   highs: 2};
      tbl[2] = '{p: 3,   d: 5, c: 1, done_at: 4,   highs: 3};
      tbl[3] = '{p: 4,   d: 2, c: 0, done_at: 1,   highs: 0};
      tbl[4] = '{p: 1,   d: 1, c: 5, done_at: 6,   highs: 5};
      tbl[5] = '{p: 5,   d: 0, c: 2, done_at: 11,  highs: 0};
      tbl[6] = '{p: 255, d: 1, c: 1, done_at: 256, highs: 1};
      tbl[7] = '{p: 3,   d: 3, c: 4, done_at: 13,  highs: 12};

      rst_n          = 1'b0;
      i_cmd_valid    = 1'b0;
      i_cmd_period   = '0;
      i_cmd_duration = '0;
      i_cmd_count    = '0;
      i_abort        = 1'b0;

      // Reset held three cycles
      repeat (3) begin
         @(negedge clk);
         chk("reset_hold", {28'd0, o_pulse, o_done, o_busy, 1'b0}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_release", obs(), mk(1'b0, 1'b0, 1'b0, 1'b1, 0));

      // Directed table
      foreach (tbl[i]) begin
         issue(tbl[i].p, tbl[i].d, tbl[i].c, 1'b0);
         observe(tbl[i].p, tbl[i].d, tbl[i].c, done_at, highs);
         chk("tbl_done_at", 32'(done_at), 32'(tbl[i].done_at));
         chk("tbl_highs", 32'(highs), 32'(tbl[i].highs));
      end

      // Held valid with changing fields: ignored until the first ready cycle
      issue(4, 2, 3, 1'b1);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         chk("hs_not_ready", {31'd0, o_cmd_ready}, 32'd0);
         if (k <= 12) chk("hs_pulse_a", {31'd0, o_pulse}, {31'd0, (((k - 1) % 4) < 2)});
         if (k == 13) chk("hs_done_a", {31'd0, o_done}, 32'd1);
         if (k < 13) begin
            i_cmd_period   = CNT_W'($urandom_range(0, 255));
            i_cmd_duration = CNT_W'($urandom_range(0, 255));
            i_cmd_count    = BURST_W'($urandom_range(0, 255));
         end else begin
            i_cmd_period   = CNT_W'(2);
            i_cmd_duration = CNT_W'(1);
            i_cmd_count    = BURST_W'(2);
         end
      end
      @(negedge clk);
      chk("hs_ready", {31'd0, o_cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
      observe(2, 1, 2, done_at, highs);
      chk("hs_b_done_at", 32'(done_at), 32'd5);
      chk("hs_b_highs", 32'(highs), 32'd2);

      // Mid-burst reset at cycle 6 of the basic burst
      issue(4, 2, 3, 1'b0);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_async", {29'd0, o_pulse, o_done, o_busy}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("mid_reset_hold", {28'd0, o_pulse, o_done, o_busy, 1'b0}, 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("mid_reset_quiet", obs(), mk(1'b0, 1'b0, 1'b0, 1'b1, 0));
      end
      issue(3, 1, 2, 1'b0);
      observe(3, 1, 2, done_at, highs);
      chk("post_reset_done_at", 32'(done_at), 32'd7);

`ifdef PULSE_BURST_ABORT_EN
      // Abort asserted in cycle 5 of the basic burst
      issue(4, 2, 3, 1'b0);
      repeat (5) @(negedge clk);
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort = 1'b0;
      @(negedge clk);
      chk("abort_done", obs(), mk(1'b0, 1'b1, 1'b1, 1'b0, 1));
      @(negedge clk);
      chk("abort_ready", obs(), mk(1'b0, 1'b0, 1'b0, 1'b1, 1));
      // Abort in IDLE, coinciding with an accept, is ignored
      i_abort = 1'b1;
      @(negedge clk);
      chk("abort_idle", obs(), mk(1'b0, 1'b0, 1'b0, 1'b1, 1));
      issue(2, 1, 2, 1'b0);
      i_abort = 1'b0;
      observe(2, 1, 2, done_at, highs);
      chk("abort_idle_done_at", 32'(done_at), 32'd5);
`endif

      // Randomized commands against the model
      for (int n = 0; n < 40; n++) begin
         p = $urandom_range(0, 6);
         d = $urandom_range(0, 7);
         c = $urandom_range(0, 4);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("rand_idle", {31'd0, o_cmd_ready}, 32'd1);
         end
         issue(p, d, c, 1'b0);
         observe(p, d, c, done_at, highs);
         chk("rand_done_at", 32'(done_at), 32'(c * ((p == 0) ? 1 : p) + 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulse_burst_ctrl.md
# pulse_burst_ctrl

Sequencing controller for the team's periodic pulse datapath. Accepts a burst command (period, duration, pulse count) over a valid/ready handshake, generates exactly that many pulses on `o_pulse` with run-time programmable timing, then reports completion. It sits between a host or command FSM and any logic that needs a timed burst of strobes. It replaces compile-time-only period/duration selection where timing must change per burst.

## Interface
- `CNT_W`, default 8: width of the period and duration fields and of the internal phase counter.
- `BURST_W`, default 8: width of the pulse-count field and of `o_pulse_idx`.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  controller can accept; high only in IDLE.
- `i_cmd_period`  in  CNT_W  cycles per pulse period; 0 is treated as 1.
- `i_cmd_duration`  in  CNT_W  high cycles per period; values ≥ period give a constant high for the whole burst.
- `i_cmd_count`  in  BURST_W  number of pulses in the burst; 0 is legal.
- `o_pulse`  out  1  generated pulse train.
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  single-cycle completion strobe.
- `o_pulse_idx`  out  BURST_W  index of the current pulse, starting at 0.
- `i_abort`  in  1  present only with `PULSE_BURST_ABORT_EN`.

## Operation
- States:
  - IDLE: `o_cmd_ready`=1.
  - RUN: emitting pulses.
  - DONE: exactly one cycle, `o_done`=1.
- Accept: on `i_cmd_valid && o_cmd_ready`, register period (0 becomes 1), duration and count.
  - Count ≠ 0: go to RUN with phase=0 and idx=0.
  - Count = 0: go directly to DONE; no pulse is emitted.
- RUN:
  - `o_pulse = (phase < duration_q)`, derived from registered state only (glitch-free, no input-to-output path).
  - Phase increments each cycle. At `phase == period_q-1`, phase wraps to 0 and idx increments.
  - If the wrap occurs with `idx == count_q-1`, go to DONE.
- DONE: go to IDLE on the next cycle.
- Outside RUN, `o_pulse`=0 and phase=0. `o_pulse_idx` holds its last value until the next accept, which clears it.
- Command inputs are ignored while `o_cmd_ready`=0. No queuing.
- Arithmetic: phase and idx compare at full width and never overflow. Phase is at most `period_q-1`; idx is at most `count_q-1`.
- Burst length is `count_q × period_q` cycles in RUN.
- `rst_n` low at any time, including mid-burst:
  - State goes to IDLE; phase, idx and registered fields go to 0.
  - `o_pulse`=0, `o_done`=0, `o_busy`=0, `o_cmd_ready`=1 (after release).
  - The in-flight burst is discarded and not resumed.

## Timing
- Reset values:
  - `o_pulse`=0, `o_done`=0, `o_busy`=0, `o_pulse_idx`=0.
  - `o_cmd_ready`=1 once `rst_n` is high.
- Command accepted in cycle T:
  - First pulse cycle is T+1 (if duration>0).
  - `o_done` is asserted in cycle T+1+count·period.
  - `o_cmd_ready` returns in the following cycle.
- Count=0: `o_done` at T+1, ready at T+2.
- Minimum command-to-command spacing is count·period+2 cycles. Back-to-back acceptance is never possible in DONE.
- Period=1 with duration≥1 gives `o_pulse` high continuously for `count` cycles.

## Configuration
- `PULSE_BURST_ABORT_EN` defined:
  - Adds the `i_abort` port.
  - `i_abort`=1 in RUN forces DONE on the next cycle. `o_pulse` drops in that same next cycle and `o_done` pulses once.
  - `i_abort` in IDLE or DONE is ignored, including when it coincides with an accept; the accept proceeds.
- `PULSE_BURST_ABORT_EN` not defined: no `i_abort` port; bursts always run to completion.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, release.
  - Response: `o_pulse`=0, `o_done`=0, `o_busy`=0, `o_cmd_ready`=1.
- Basic burst: period=4, duration=2, count=3 accepted at cycle 0.
  - `o_pulse` high in cycles 1–2, 5–6, 9–10.
  - `o_pulse_idx` reads 0, 1, 2 across the bursts.
  - `o_done` in cycle 13; ready in cycle 14.
- Edge values:
  - period=0, duration=1, count=2: treated as period=1; `o_pulse` high in cycles 1–2, done in cycle 3.
  - duration=5, period=3, count=1: high in cycles 1–3.
  - count=0: no pulse, done in cycle 1.
- Handshake: hold `i_cmd_valid`=1 with changing fields during a burst.
  - Fields are ignored until ready. The second command is accepted exactly in the first ready cycle, and its timing matches its own fields.
- Mid-burst reset: assert `rst_n`=0 at cycle 6 of the basic burst.
  - `o_pulse` drops asynchronously, and `o_done` never fires.
  - After release, a fresh command runs correctly.
- Abort (macro defined only): `i_abort` at cycle 5 of the basic burst.
  - `o_pulse`=0 from cycle 6, `o_done` in cycle 6, ready in cycle 7.
  - `i_abort` in IDLE has no effect.
